// File: rtl/video_pkg.sv
// Shared defaults and register-port encodings for the video compositor block.
// Pure declarations; no logic, no latency, no flow control.
package video_pkg;

  localparam int DEF_COLOR_BITS = 4;
  localparam int DEF_COORD_BITS = 16;
  localparam int PIPE_LATENCY   = 3;

  typedef enum logic [1:0] {
    FIELD_POS_X  = 2'd0,
    FIELD_POS_Y  = 2'd1,
    FIELD_ENABLE = 2'd2,
    FIELD_RSVD   = 2'd3
  } reg_field_e;

endpackage

// File: rtl/video_sprite_hit.sv
// Per-sprite shadow/active position+enable registers, hit test and local coordinates.
// Outputs registered one cycle after x/y; writes always accepted, commit on frame_start.
module video_sprite_hit
  import video_pkg::*;
#(
  parameter int SPRITE_LOG2 = 5,
  parameter int COORD_BITS  = DEF_COORD_BITS
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   wr_en_i,
  input  reg_field_e             wr_field_i,
  input  logic [COORD_BITS-1:0]  wr_data_i,
  input  logic                   frame_start_i,
  input  logic [COORD_BITS-1:0]  x_i,
  input  logic [COORD_BITS-1:0]  y_i,
  input  logic                   visible_i,
  output logic                   active_o,
  output logic [SPRITE_LOG2-1:0] loc_x_o,
  output logic [SPRITE_LOG2-1:0] loc_y_o
);

  localparam logic [COORD_BITS:0] EDGE =
    {{(COORD_BITS-SPRITE_LOG2){1'b0}}, 1'b1, {SPRITE_LOG2{1'b0}}};

  logic [COORD_BITS-1:0]  shd_x_q, shd_x_d, shd_y_q, shd_y_d;
  logic [COORD_BITS-1:0]  act_x_q, act_x_d, act_y_q, act_y_d;
  logic                   shd_en_q, shd_en_d, act_en_q, act_en_d;
  logic                   active_q, active_d;
  logic [SPRITE_LOG2-1:0] loc_x_q, loc_x_d, loc_y_q, loc_y_d;
  logic [COORD_BITS:0]    end_x, end_y;
  logic                   in_x, in_y;

  always_comb begin
    shd_x_d  = shd_x_q;
    shd_y_d  = shd_y_q;
    shd_en_d = shd_en_q;
    if (wr_en_i) begin
      case (wr_field_i)
        FIELD_POS_X:  shd_x_d  = wr_data_i;
        FIELD_POS_Y:  shd_y_d  = wr_data_i;
        FIELD_ENABLE: shd_en_d = wr_data_i[0];
        default:      ;
      endcase
    end
    // Commit takes the post-write shadow so a same-cycle write lands this frame.
    act_x_d  = frame_start_i ? shd_x_d  : act_x_q;
    act_y_d  = frame_start_i ? shd_y_d  : act_y_q;
    act_en_d = frame_start_i ? shd_en_d : act_en_q;
  end

  // Extra top bit keeps sprites near the coordinate maximum clipped instead of wrapping.
  assign end_x = {1'b0, act_x_q} + EDGE;
  assign end_y = {1'b0, act_y_q} + EDGE;
  assign in_x  = (x_i >= act_x_q) && ({1'b0, x_i} < end_x);
  assign in_y  = (y_i >= act_y_q) && ({1'b0, y_i} < end_y);

  always_comb begin
    active_d = act_en_q && in_x && in_y && visible_i;
    loc_x_d  = SPRITE_LOG2'(x_i - act_x_q);
    loc_y_d  = SPRITE_LOG2'(y_i - act_y_q);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      shd_x_q  <= '0;
      shd_y_q  <= '0;
      shd_en_q <= 1'b0;
      act_x_q  <= '0;
      act_y_q  <= '0;
      act_en_q <= 1'b0;
      active_q <= 1'b0;
      loc_x_q  <= '0;
      loc_y_q  <= '0;
    end else begin
      shd_x_q  <= shd_x_d;
      shd_y_q  <= shd_y_d;
      shd_en_q <= shd_en_d;
      act_x_q  <= act_x_d;
      act_y_q  <= act_y_d;
      act_en_q <= act_en_d;
      active_q <= active_d;
      loc_x_q  <= loc_x_d;
      loc_y_q  <= loc_y_d;
    end
  end

  assign active_o = active_q;
  assign loc_x_o  = loc_x_q;
  assign loc_y_o  = loc_y_q;

endmodule

// File: rtl/video_layer_compositor.sv
// Composites a background stream with NUM_SPRITES fixed-priority sprite layers (index 0 on top).
// Latency 3 cycles from x/y/visible/syncs to r/g/b/de/syncs; no backpressure anywhere.
module video_layer_compositor
  import video_pkg::*;
#(
  parameter int NUM_SPRITES = 4,
  parameter int SPRITE_LOG2 = 5,
  parameter int COLOR_BITS  = DEF_COLOR_BITS,
  parameter int COORD_BITS  = DEF_COORD_BITS,
  localparam int SEL_BITS   = (NUM_SPRITES > 1) ? $clog2(NUM_SPRITES) : 1
) (
  input  logic                               clk,
  input  logic                               reset,
  input  logic                               visible,
  input  logic                               hsync_in,
  input  logic                               vsync_in,
  input  logic                               frame_start,
  input  logic [COORD_BITS-1:0]              x,
  input  logic [COORD_BITS-1:0]              y,
  input  logic [COLOR_BITS-1:0]              bg_r,
  input  logic [COLOR_BITS-1:0]              bg_g,
  input  logic [COLOR_BITS-1:0]              bg_b,
  output logic [NUM_SPRITES*SPRITE_LOG2-1:0] spr_x,
  output logic [NUM_SPRITES*SPRITE_LOG2-1:0] spr_y,
  output logic [NUM_SPRITES-1:0]             spr_active,
  input  logic [NUM_SPRITES*COLOR_BITS-1:0]  spr_r,
  input  logic [NUM_SPRITES*COLOR_BITS-1:0]  spr_g,
  input  logic [NUM_SPRITES*COLOR_BITS-1:0]  spr_b,
  input  logic [NUM_SPRITES-1:0]             spr_opaque,
  input  logic                               reg_we,
  input  logic [SEL_BITS-1:0]                reg_sel,
  input  logic [1:0]                         reg_field,
  input  logic [COORD_BITS-1:0]              reg_wdata,
  output logic [COLOR_BITS-1:0]              r,
  output logic [COLOR_BITS-1:0]              g,
  output logic [COLOR_BITS-1:0]              b,
  output logic                               de,
  output logic                               hsync,
  output logic                               vsync
);

  typedef struct packed {
    logic                  de;
    logic                  hs;
    logic                  vs;
    logic [COLOR_BITS-1:0] r;
    logic [COLOR_BITS-1:0] g;
    logic [COLOR_BITS-1:0] b;
  } pix_t;

  pix_t                   s0_q, s0_d, s1_q, out_q, out_d;
  logic [NUM_SPRITES-1:0] act0, act1_q;
  logic [COLOR_BITS-1:0]  mux_r, mux_g, mux_b;

  for (genvar i = 0; i < NUM_SPRITES; i++) begin : g_spr
    video_sprite_hit #(
      .SPRITE_LOG2 (SPRITE_LOG2),
      .COORD_BITS  (COORD_BITS)
    ) u_hit (
      .clk           (clk),
      .reset         (reset),
      .wr_en_i       (reg_we && (reg_sel == SEL_BITS'(i))),
      .wr_field_i    (reg_field_e'(reg_field)),
      .wr_data_i     (reg_wdata),
      .frame_start_i (frame_start),
      .x_i           (x),
      .y_i           (y),
      .visible_i     (visible),
      .active_o      (act0[i]),
      .loc_x_o       (spr_x[i*SPRITE_LOG2 +: SPRITE_LOG2]),
      .loc_y_o       (spr_y[i*SPRITE_LOG2 +: SPRITE_LOG2])
    );
  end

  assign spr_active = act0;
  assign s0_d = '{de: visible, hs: hsync_in, vs: vsync_in, r: bg_r, g: bg_g, b: bg_b};

  // Sprite colours arrive one cycle after spr_x/spr_y, so hits are delayed once more to line up.
  always_comb begin
    mux_r = s1_q.r;
    mux_g = s1_q.g;
    mux_b = s1_q.b;
    for (int i = NUM_SPRITES - 1; i >= 0; i--) begin
      if (act1_q[i] && spr_opaque[i]) begin
        mux_r = spr_r[i*COLOR_BITS +: COLOR_BITS];
        mux_g = spr_g[i*COLOR_BITS +: COLOR_BITS];
        mux_b = spr_b[i*COLOR_BITS +: COLOR_BITS];
      end
    end
    out_d   = s1_q;
    out_d.r = s1_q.de ? mux_r : '0;
    out_d.g = s1_q.de ? mux_g : '0;
    out_d.b = s1_q.de ? mux_b : '0;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      s0_q   <= '0;
      s1_q   <= '0;
      act1_q <= '0;
      out_q  <= '0;
    end else begin
      s0_q   <= s0_d;
      s1_q   <= s0_q;
      act1_q <= act0;
      out_q  <= out_d;
    end
  end

  assign r     = out_q.r;
  assign g     = out_q.g;
  assign b     = out_q.b;
  assign de    = out_q.de;
  assign hsync = out_q.hs;
  assign vsync = out_q.vs;

endmodule

// File: tb/tb_video_layer_compositor.sv
// Randomised bench: drives pixel windows/frames, emulates sprite sources, checks against a reference model.
module tb_video_layer_compositor;

  localparam int NS = 4;
  localparam int L  = 5;
  localparam int CB = 4;
  localparam int XB = 16;

  logic              clk = 1'b0;
  logic              reset = 1'b1;
  logic              visible = 1'b0, hsync_in = 1'b0, vsync_in = 1'b0, frame_start = 1'b0;
  logic [XB-1:0]     x = '0, y = '0;
  logic [CB-1:0]     bg_r = '0, bg_g = '0, bg_b = '0;
  logic [NS*L-1:0]   spr_x, spr_y;
  logic [NS-1:0]     spr_active;
  logic [NS*CB-1:0]  spr_r = '0, spr_g = '0, spr_b = '0;
  logic [NS-1:0]     spr_opaque = '0;
  logic              reg_we = 1'b0;
  logic [1:0]        reg_sel = '0;
  logic [1:0]        reg_field = '0;
  logic [XB-1:0]     reg_wdata = '0;
  logic [CB-1:0]     r, g, b;
  logic              de, hsync, vsync;

  always #5 clk = ~clk;

  video_layer_compositor dut (
    .clk(clk), .reset(reset), .visible(visible), .hsync_in(hsync_in), .vsync_in(vsync_in),
    .frame_start(frame_start), .x(x), .y(y), .bg_r(bg_r), .bg_g(bg_g), .bg_b(bg_b),
    .spr_x(spr_x), .spr_y(spr_y), .spr_active(spr_active),
    .spr_r(spr_r), .spr_g(spr_g), .spr_b(spr_b), .spr_opaque(spr_opaque),
    .reg_we(reg_we), .reg_sel(reg_sel), .reg_field(reg_field), .reg_wdata(reg_wdata),
    .r(r), .g(g), .b(b), .de(de), .hsync(hsync), .vsync(vsync)
  );

  typedef struct {
    bit              rst;
    logic [2:0]      sync;
    logic [11:0]     rgb;
    logic [NS-1:0]   act;
    logic [NS*L-1:0] lx;
    logic [NS*L-1:0] ly;
  } hist_t;

  int          n_checks = 0;
  int          n_fail = 0;
  int          cyc = 8;
  hist_t       hist[8];
  logic [15:0] shd_x[NS], shd_y[NS], act_x[NS], act_y[NS];
  bit          shd_en[NS], act_en[NS];
  int          opq_mode[NS];
  logic [NS*L-1:0] sx_prev = '0, sy_prev = '0;

  bit fw_we = 0;  int fw_sel, fw_fld;  logic [15:0] fw_wd;
  int mw_at = -1; int mw_sel, mw_fld; logic [15:0] mw_wd;
  int rst_at = -1;
  bit rnd_wr = 0, drop = 0;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s @cyc %0d: got %0h expected %0h", tag, cyc, got, exp);
    end
  endtask

  function automatic logic [11:0] spr_col(int i, logic [L-1:0] lx, logic [L-1:0] ly);
    return {4'(15 - i), 4'(lx >> 1), 4'(ly >> 1)};
  endfunction

  function automatic bit spr_opq(int i, logic [L-1:0] lx, logic [L-1:0] ly);
    case (opq_mode[i])
      0:       return 1'b1;
      1:       return lx >= 5'd16;
      default: return ((lx ^ ly ^ 5'(i)) & 5'd1) == 5'd1;
    endcase
  endfunction

  // One pixel clock: check outputs, serve sprite sources, model the pixel, drive inputs.
  task automatic step(input logic [15:0] px, input logic [15:0] py, input bit vis, input bit hs,
                      input bit vs, input bit fs, input logic [11:0] bg, input bit we, input int sel,
                      input int fld, input logic [15:0] wd, input bit rst);
    hist_t h, p1, p3;
    logic [11:0] col, c;
    logic [15:0] dx, dy;
    bit hx, hy;
    @(negedge clk);
    p1 = hist[(cyc - 1) % 8];
    check_eq("spr_active", 64'(spr_active), p1.rst ? 64'd0 : 64'(p1.act));
    check_eq("spr_x", 64'(spr_x), p1.rst ? 64'd0 : 64'(p1.lx));
    check_eq("spr_y", 64'(spr_y), p1.rst ? 64'd0 : 64'(p1.ly));
    p3 = hist[(cyc - 3) % 8];
    if (hist[(cyc - 1) % 8].rst || hist[(cyc - 2) % 8].rst || p3.rst) begin
      check_eq("rgb", 64'({r, g, b}), 64'd0);
      check_eq("sync", 64'({de, hsync, vsync}), 64'd0);
    end else begin
      check_eq("rgb", 64'({r, g, b}), 64'(p3.rgb));
      check_eq("sync", 64'({de, hsync, vsync}), 64'(p3.sync));
    end
    for (int i = 0; i < NS; i++) begin
      c = spr_col(i, sx_prev[i*L +: L], sy_prev[i*L +: L]);
      spr_r[i*CB +: CB] = c[11:8];
      spr_g[i*CB +: CB] = c[7:4];
      spr_b[i*CB +: CB] = c[3:0];
      spr_opaque[i]     = spr_opq(i, sx_prev[i*L +: L], sy_prev[i*L +: L]);
    end
    sx_prev = spr_x;
    sy_prev = spr_y;
    h.rst = rst;
    h.act = '0;
    col = bg;
    for (int i = NS - 1; i >= 0; i--) begin
      dx = px - act_x[i];
      dy = py - act_y[i];
      hx = (px >= act_x[i]) && (int'(px) < int'(act_x[i]) + (1 << L));
      hy = (py >= act_y[i]) && (int'(py) < int'(act_y[i]) + (1 << L));
      h.act[i] = act_en[i] && hx && hy && vis;
      h.lx[i*L +: L] = dx[L-1:0];
      h.ly[i*L +: L] = dy[L-1:0];
      if (h.act[i] && spr_opq(i, dx[L-1:0], dy[L-1:0])) col = spr_col(i, dx[L-1:0], dy[L-1:0]);
    end
    h.rgb  = vis ? col : 12'd0;
    h.sync = {vis, hs, vs};
    hist[cyc % 8] = h;
    if (rst) begin
      for (int i = 0; i < NS; i++) begin
        shd_x[i] = 0; shd_y[i] = 0; shd_en[i] = 0;
        act_x[i] = 0; act_y[i] = 0; act_en[i] = 0;
      end
    end else begin
      if (we && sel < NS) begin
        if (fld == 0) shd_x[sel] = wd;
        else if (fld == 1) shd_y[sel] = wd;
        else if (fld == 2) shd_en[sel] = wd[0];
      end
      if (fs) begin
        act_x = shd_x; act_y = shd_y; act_en = shd_en;
      end
    end
    reset = rst; visible = vis; hsync_in = hs; vsync_in = vs; frame_start = fs;
    x = px; y = py; bg_r = bg[11:8]; bg_g = bg[7:4]; bg_b = bg[3:0];
    reg_we = we; reg_sel = 2'(sel); reg_field = 2'(fld); reg_wdata = wd;
    cyc++;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(0, 0, 0, 0, 0, 0, 12'($urandom), 0, 0, 0, 0, 0);
  endtask

  task automatic wr(input int sel, input int fld, input int data);
    step(0, 0, 0, 0, 0, 0, 12'($urandom), 1, sel, fld, 16'(data), 0);
  endtask

  task automatic run_frame(input int xs, input int nx, input int ys, input int ny);
    int pidx = 0;
    step(0, 0, 0, 0, 1, 1, 12'($urandom), fw_we, fw_sel, fw_fld, fw_wd, 0);
    fw_we = 0;
    for (int row = 0; row < ny; row++) begin
      for (int col = 0; col < nx; col++) begin
        bit we; int sel, fld; logic [15:0] wd; bit vis, rst;
        we = 0; sel = 0; fld = 0; wd = 0;
        if (rnd_wr && $urandom_range(0, 49) == 0) begin
          we = 1; sel = $urandom_range(0, NS - 1); fld = $urandom_range(0, 3);
          wd = 16'(xs + $urandom_range(0, nx));
        end
        if (pidx == mw_at) begin
          we = 1; sel = mw_sel; fld = mw_fld; wd = mw_wd;
        end
        rst = (pidx == rst_at) || (pidx == rst_at + 1);
        vis = !(drop && $urandom_range(0, 15) == 0);
        step(16'(xs + col), 16'(ys + row), vis, 0, 0, 0, 12'($urandom), we, sel, fld, wd, rst);
        pidx++;
      end
      step(0, 0, 0, 1, 0, 0, 12'($urandom), 0, 0, 0, 0, 0);
      step(0, 0, 0, 1, 0, 0, 12'($urandom), 0, 0, 0, 0, 0);
    end
    mw_at = -1;
    rst_at = -1;
  endtask

  initial begin
    for (int i = 0; i < 8; i++) hist[i].rst = 1;
    for (int i = 0; i < NS; i++) begin
      shd_x[i] = 0; shd_y[i] = 0; shd_en[i] = 0;
      act_x[i] = 0; act_y[i] = 0; act_en[i] = 0; opq_mode[i] = 0;
    end
    for (int i = 0; i < 4; i++) step(0, 0, 0, 0, 0, 0, 12'($urandom), 0, 0, 0, 0, 1);
    idle(3);

    // Empty frame: background only, delayed 3 cycles.
    run_frame(0, 40, 0, 10);

    // Single opaque sprite at (100,50).
    wr(0, 0, 100); wr(0, 1, 50); wr(0, 2, 1);
    run_frame(90, 51, 45, 40);

    // Overlap at (200,200); sprite 0 transparent on its left half.
    opq_mode[0] = 1;
    wr(0, 0, 200); wr(0, 1, 200); wr(1, 0, 200); wr(1, 1, 200); wr(1, 2, 1);
    run_frame(195, 40, 198, 8);

    // Mid-frame write waits for the next commit; a frame_start write applies at once.
    opq_mode[0] = 0;
    wr(1, 2, 0);
    mw_at = 30; mw_sel = 0; mw_fld = 0; mw_wd = 16'd300;
    run_frame(195, 140, 200, 4);
    run_frame(195, 140, 200, 4);
    fw_we = 1; fw_sel = 0; fw_fld = 0; fw_wd = 16'd250;
    run_frame(195, 140, 200, 4);

    // Clipping near the coordinate maximum, no wrap to 0.
    wr(0, 2, 0);
    wr(2, 0, 65530); wr(2, 1, 65526); wr(2, 2, 1);
    wr(3, 0, 2); wr(3, 1, 65530); wr(3, 2, 1);
    run_frame(65520, 48, 65524, 14);

    // Reset mid visible line, then the sprite stays hidden next frame.
    wr(2, 2, 0); wr(3, 2, 0);
    wr(0, 0, 10); wr(0, 1, 2); wr(0, 2, 1);
    run_frame(0, 40, 0, 10);
    rst_at = 3 * 40 + 15;
    run_frame(0, 40, 0, 10);
    run_frame(0, 40, 0, 10);

    // Random positions, opacity, mid-frame writes and visible dropouts.
    rnd_wr = 1; drop = 1;
    for (int f = 0; f < 4; f++) begin
      for (int i = 0; i < NS; i++) begin
        opq_mode[i] = $urandom_range(0, 2);
        wr(i, 0, 100 + $urandom_range(0, 60));
        wr(i, 1, 20 + $urandom_range(0, 30));
        wr(i, 2, $urandom_range(0, 1) | (f == 0 ? 1 : 0));
      end
      run_frame(90, 48, 15, 20);
      run_frame(90, 48, 15, 20);
    end
    rnd_wr = 0; drop = 0;
    idle(6);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/video_layer_compositor.md
Name: video_layer_compositor

Overview:
- Parametrised successor to the single-pointer compositor: merges a background colour stream with NUM_SPRITES fixed-size sprite layers under a fixed priority order.
- Sits between video_timing/background source and the output pins.
- Generates per-sprite local coordinates, consumes each sprite source's registered colour/opacity, and outputs final RGB plus delayed sync/DE.
- Sprite positions and enables are programmed through a simple write port and committed only at frame start, so updates never tear.

Parameters:
NUM_SPRITES, 4, number of sprite layers; index 0 has highest priority
SPRITE_LOG2, 5, sprite edge is 2**SPRITE_LOG2 pixels (32x32 default)
COLOR_BITS, 4, bits per colour channel
COORD_BITS, 16, width of screen x/y and sprite position registers

Ports:
clk  in  1  pixel clock
reset  in  1  synchronous, active-high reset
visible  in  1  data-enable from timing
hsync_in  in  1  hsync from timing
vsync_in  in  1  vsync from timing
frame_start  in  1  one-cycle pulse marking first cycle of a frame; commits shadow registers
x  in  COORD_BITS  current pixel column
y  in  COORD_BITS  current pixel row
bg_r, bg_g, bg_b  in  COLOR_BITS each  background colour, aligned with x/y
spr_x  out  NUM_SPRITES*SPRITE_LOG2  local column per sprite; sprite i occupies slice i
spr_y  out  NUM_SPRITES*SPRITE_LOG2  local row per sprite
spr_active  out  NUM_SPRITES  sprite i covers the current pixel
spr_r, spr_g, spr_b  in  NUM_SPRITES*COLOR_BITS each  sprite colour, one cycle after spr_x/spr_y
spr_opaque  in  NUM_SPRITES  sprite pixel opaque, one cycle after spr_x/spr_y
reg_we  in  1  write strobe
reg_sel  in  $clog2(NUM_SPRITES)  target sprite
reg_field  in  2  0 = pos_x, 1 = pos_y, 2 = enable (wdata[0]), 3 = reserved (ignored)
reg_wdata  in  COORD_BITS  write data
r, g, b  out  COLOR_BITS each  composited colour
de  out  1  delayed visible
hsync, vsync  out  1 each  delayed syncs

Behaviour:
- Reset: all shadow and active positions are 0; all enables are 0; spr_active is 0; spr_x/spr_y are 0; r/g/b are 0; de/hsync/vsync are 0.
- Write port: a write takes effect in shadow registers on the clock edge with reg_we=1. It is always accepted; there is no backpressure. Out-of-range reg_sel and field 3 are ignored.
- Commit: on frame_start=1, active registers are loaded from shadow. If a write and frame_start occur in the same cycle, the commit includes that write.
- Stage 0 (registered, cycle N+1):
  - Hit test for sprite i: enable_i AND x >= pos_x_i AND x < pos_x_i + 2**SPRITE_LOG2 AND the same test for y.
  - The addition is done at COORD_BITS+1 width, so a sprite near the coordinate maximum is clipped and never wraps to column/row 0.
  - spr_active_i <= hit AND visible.
  - spr_x_i <= (x - pos_x_i)[SPRITE_LOG2-1:0], same for y.
  - Background, visible, hsync_in and vsync_in are delayed by one stage.
- Stage 1 (cycle N+2): sprite sources return colour/opacity. Select the lowest index i with stage-0 spr_active_i AND spr_opaque_i. If none, select the delayed background.
- Stage 2 (cycle N+3): register r/g/b, de, hsync, vsync.
  - Total latency from x/y/visible/syncs to outputs is 3 cycles. Syncs and de keep exact alignment.
  - r/g/b are forced to 0 whenever the output de = 0.
- A sprite with enable=1 but entirely off-screen never asserts spr_active.
- Overlapping sprites: the higher-priority opaque pixel wins. A transparent higher sprite reveals the lower sprite or the background.
- Reset asserted mid-frame: on the next edge all pipeline stages clear, and outputs hold reset values while reset=1. After release, the active registers stay 0/disabled until the first frame_start following a write.

Decomposition:
- Shared package video_pkg: COLOR_BITS/COORD_BITS defaults, reg_field encodings (FIELD_POS_X, FIELD_POS_Y, FIELD_ENABLE), PIPE_LATENCY=3.
- Sub-module video_sprite_hit: one instance per sprite. It holds the shadow/active position+enable registers, the hit compare and the local-coordinate subtraction (stage 0).
- Top level: generate loop, priority mux, delay lines, output registers.

Test Plan:
- Reset, then 1 frame with no writes -> de tracks visible delayed 3 cycles; r/g/b equal bg delayed 3; spr_active is always 0.
- Write sprite 0 pos (100,50), enable=1, then frame_start; all sprite pixels opaque red -> output is red exactly for x in 100..131, y in 50..81; spr_x=0 at x=100, spr_x=31 at x=131.
- Sprites 0 and 1 both at (200,200), sprite 0 transparent in its left half -> left half shows sprite 1 colour, right half shows sprite 0.
- Write pos_x=300 mid-frame without frame_start -> position unchanged for rest of frame; moves to 300 after next frame_start. A write in the same cycle as frame_start -> applied that frame.
- Sprite 2 at pos_x=65530, width 32 -> never active at x=0..25 (no wrap); sprite at x=-clip rows behaves the same for y.
- Assert reset for 2 cycles mid-visible-line -> r/g/b/de/hsync/vsync are 0 the next cycle; enables cleared, sprite hidden in the subsequent frame.
